// File: rtl/control_unit_if.sv
// Control bus between the accumulator-processor control FSM and its datapath.
// The master side is the control unit; the slave side is the datapath.
interface control_unit_if #(
    parameter int ICNT_W = 8
);
    logic [2:0]        IR;
    logic              Aeq0;
    logic              Apos;
    logic              Enter;
    logic              IRload;
    logic              JMPmux;
    logic              PCload;
    logic              Meminst;
    logic              MemWr;
    logic [1:0]        Asel;
    logic              Aload;
    logic              Sub;
    logic              Halt;
    logic [3:0]        State;
    logic [ICNT_W-1:0] Icount;

    modport master (
        input  IR, Aeq0, Apos, Enter,
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt,
        output State, Icount
    );

    modport slave (
        output IR, Aeq0, Apos, Enter,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt,
        input  State, Icount
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit accumulator processor,
// with a retired-instruction counter.
module control_unit #(
    parameter int ICNT_W = 8
) (
    input  logic              clock,
    input  logic              Reset,
    control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              retire;
    logic [ICNT_W-1:0] icount;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state  <= S_FETCH;
            icount <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                icount <= icount + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        bus.IRload  = 1'b0;
        bus.JMPmux  = 1'b0;
        bus.PCload  = 1'b0;
        bus.Meminst = 1'b0;
        bus.MemWr   = 1'b0;
        bus.Asel    = 2'b00;
        bus.Aload   = 1'b0;
        bus.Sub     = 1'b0;
        bus.Halt    = 1'b0;

        case (state)
            S_FETCH: begin
                bus.IRload = 1'b1;
                bus.PCload = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                bus.Meminst = 1'b1;
                // Execute states sit at 8 + opcode, so the opcode selects the state directly.
                state_next  = state_t'({1'b1, bus.IR});
                // HALT never leaves its state, so it is counted on the way in.
                retire      = (bus.IR == 3'b111);
            end
            S_LOAD: begin
                bus.Meminst = 1'b1;
                bus.Asel    = 2'b10;
                bus.Aload   = 1'b1;
                state_next  = S_FETCH;
                retire      = 1'b1;
            end
            S_STORE: begin
                bus.Meminst = 1'b1;
                bus.MemWr   = 1'b1;
                state_next  = S_FETCH;
                retire      = 1'b1;
            end
            S_ADD: begin
                bus.Meminst = 1'b1;
                bus.Aload   = 1'b1;
                state_next  = S_FETCH;
                retire      = 1'b1;
            end
            S_SUB: begin
                bus.Meminst = 1'b1;
                bus.Sub     = 1'b1;
                bus.Aload   = 1'b1;
                state_next  = S_FETCH;
                retire      = 1'b1;
            end
            S_INPUT: begin
                bus.Asel  = 2'b01;
                bus.Aload = bus.Enter;
                if (bus.Enter) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_JZ: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Aeq0;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_JPOS: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Apos;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT: begin
                bus.Halt = 1'b1;
            end
            default: begin
                // Unused encodings recover to a fresh fetch.
                state_next = S_FETCH;
            end
        endcase
    end

    assign bus.State  = state;
    assign bus.Icount = icount;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle control FSM for the 8-bit accumulator processor.
- Consumes the 3-bit opcode from the instruction register stage.
- Drives that stage's IRload, PCload, JMPmux and Meminst strobes, plus the accumulator, ALU, memory-write and I/O controls.
- Each instruction takes one fetch cycle, one decode cycle and one execute cycle. INPUT may stall in execute.

Parameters:
- ICNT_W, 8, width of the retired-instruction counter (wraps modulo 2^ICNT_W).

Ports:
- clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- IR  input  3  opcode from the instruction register (Q_IR[7:5])
- Aeq0  input  1  accumulator == 0
- Apos  input  1  accumulator > 0 (signed; zero is not positive)
- Enter  input  1  user input-valid strobe (level)
- IRload  output  1  load instruction register from RAM
- JMPmux  output  1  PC source: 0 = incrementer, 1 = IR operand
- PCload  output  1  load PC
- Meminst  output  1  RAM address source: 0 = PC, 1 = IR operand
- MemWr  output  1  RAM write enable
- Asel  output  2  accumulator input select: 00 = ALU, 01 = external input, 10 = RAM data
- Aload  output  1  load accumulator
- Sub  output  1  ALU op: 0 = add, 1 = subtract
- Halt  output  1  processor halted
- State  output  4  current state encoding (debug)
- Icount  output  ICNT_W  retired-instruction count

Behaviour:
- Opcodes:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB
  - 100 INPUT, 101 JZ, 110 JPOS, 111 HALT
- State encodings:
  - FETCH = 0, DECODE = 1, LOAD = 8, STORE = 9, ADD = 10, SUB = 11
  - INPUT = 12, JZ = 13, JPOS = 14, HALT = 15
- Moore outputs decode from the state register only. Exception: Aload in INPUT and PCload in JZ/JPOS are qualified by the named inputs.
- Any output not listed for a state is 0 in that state.
- FETCH:
  - Outputs: IRload = 1, PCload = 1, JMPmux = 0, Meminst = 0.
  - Next state: DECODE.
- DECODE:
  - Outputs: Meminst = 1, so the operand address is presented to RAM one cycle ahead of execute.
  - Next state: LOAD + IR (state 8 + opcode).
- LOAD: Meminst = 1, Asel = 10, Aload = 1. Next: FETCH.
- STORE: Meminst = 1, MemWr = 1. Next: FETCH.
- ADD: Meminst = 1, Asel = 00, Sub = 0, Aload = 1. Next: FETCH.
- SUB: Meminst = 1, Asel = 00, Sub = 1, Aload = 1. Next: FETCH.
- INPUT:
  - Outputs: Asel = 01, Aload = Enter.
  - Stays in INPUT while Enter = 0; goes to FETCH on the cycle Enter = 1.
- JZ: JMPmux = 1, PCload = Aeq0. Next: FETCH.
- JPOS: JMPmux = 1, PCload = Apos. Next: FETCH.
- HALT:
  - Outputs: Halt = 1.
  - Terminal: stays until Reset.
  - Ignores Enter and IR; no strobes asserted.
- Icount:
  - Increments by 1 on the final execute cycle of each instruction, i.e. the cycle the FSM leaves for FETCH.
  - INPUT counts only on its exit cycle.
  - Entering HALT counts once.
  - Wraps from 2^ICNT_W−1 to 0.
- Reset (Reset = 0, asynchronous):
  - State = FETCH and Icount = 0 immediately, without waiting for a clock edge.
  - Outputs take FETCH values: IRload = 1, PCload = 1, all other strobes 0, Halt = 0.
  - Reset asserted mid-instruction, including INPUT stalls and HALT, abandons the instruction with no partial Icount update.
  - The first rising edge after Reset deasserts is a fetch edge.
- Latency:
  - 3 cycles per instruction, except INPUT: 3 + (cycles waiting for Enter).
- MemWr is never asserted outside STORE. JMPmux is never asserted outside JZ/JPOS.

Test Plan:
- Reset, then IR = 000 held → state sequence 0, 1, 8, 0. Aload = 1 and Asel = 10 only in state 8; Icount = 1 after 3 edges.
- IR = 001 → state 9 asserts MemWr = 1 and Meminst = 1 for exactly one cycle. Icount increments.
- IR = 100, Enter held 0 for 5 cycles, then 1 → state 12 for 6 cycles. Aload = 1 only on the last; then FETCH; Icount +1.
- IR = 101 with Aeq0 = 1 → PCload = 1, JMPmux = 1 in state 13. Repeat with Aeq0 = 0 → PCload = 0, JMPmux = 1. Same pair for IR = 110 with Apos.
- IR = 111 → Halt = 1 permanently with all strobes 0. Toggle Enter/IR → no change. Async Reset low mid-cycle → State = 0, Icount = 0 before the next edge.
- Run 256 ADD instructions (IR = 010) → Icount wraps to 0; Sub = 0 throughout. 256 SUB instructions → Sub = 1 only in state 11.
